conv_sched: RTL



---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_tag_fifo.sv | 63 ++++++
 rtl/conv_sched.sv | 128 ++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the 3x3 convolution sequencer.
package conv_pkg;

    localparam int OUT_H = 6;
    localparam int OUT_W = 6;
    localparam int CNT_W = 3;
    localparam int TAG_W = 2 * CNT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/conv_tag_fifo.sv
// Show-ahead tag FIFO holding the coordinates of in-flight window requests.
module conv_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    import conv_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             doPush, doPop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    // A push into a full FIFO is allowed only when the head leaves in the same cycle.
    always_comb begin
        doPush = push_i && (!full_o || pop_i);
        doPop  = pop_i && !empty_o;
        wr_d   = doPush ? wr_q + PTR_W'(1) : wr_q;
        rd_d   = doPop  ? rd_q + PTR_W'(1) : rd_q;
        cnt_d  = cnt_q;
        if (doPush && !doPop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (doPop && !doPush) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_sched.sv
// Raster-order window request sequencer for the slow 3x3 convolution path.
module conv_sched #(
    parameter int OUT_H = conv_pkg::OUT_H,
    parameter int OUT_W = conv_pkg::OUT_W,
    parameter int CNT_W = conv_pkg::CNT_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             win_vld,
    input  logic             win_rdy,
    output logic [CNT_W-1:0] win_row,
    output logic [CNT_W-1:0] win_col,
    input  logic             mac_vld,
    output logic             out_vld_3x3,
    output logic [CNT_W-1:0] r_cnt,
    output logic [CNT_W-1:0] c_cnt,
    output logic             busy,
    output logic             done,
    output logic             err
);
    import conv_pkg::*;

    localparam int TAGW   = 2 * CNT_W;
    localparam int TOTAL  = OUT_H * OUT_W;
    localparam int RES_W  = $clog2(TOTAL + 1);
    localparam int CNTF_W = $clog2(DEPTH + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  row_q, row_d, col_q, col_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              err_q, err_d;

    logic              push, pop, fifoFull, fifoEmpty, lastIssue;
    logic [TAGW-1:0]   fifoHead;
    logic [CNTF_W-1:0] fifoCount;

    conv_tag_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TAGW)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  ({row_q, col_q}),
        .pop_i   (pop),
        .head_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // Issue gating looks at the registered count, so a same-cycle pop cannot reopen a full FIFO.
    always_comb begin
        win_vld   = (state_q == ISSUE) && (fifoCount < CNTF_W'(DEPTH));
        push      = win_vld && win_rdy && !fifoFull;
        pop       = mac_vld && !fifoEmpty;
        lastIssue = (row_q == CNT_W'(OUT_H - 1)) && (col_q == CNT_W'(OUT_W - 1));

        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        res_d   = pop ? res_q + RES_W'(1) : res_q;
        err_d   = err_q || (mac_vld && fifoEmpty);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    row_d   = '0;
                    col_d   = '0;
                    res_d   = '0;
                end
            end
            ISSUE: begin
                if (push) begin
                    if (lastIssue) begin
                        state_d = DRAIN;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (col_q == CNT_W'(OUT_W - 1)) begin
                        col_d = '0;
                        row_d = row_q + CNT_W'(1);
                    end else begin
                        col_d = col_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (pop && (res_q == RES_W'(TOTAL - 1))) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign win_row        = row_q;
    assign win_col        = col_q;
    assign out_vld_3x3    = pop;
    assign {r_cnt, c_cnt} = fifoHead;
    assign busy           = (state_q == ISSUE) || (state_q == DRAIN);
    assign done           = (state_q == FIN);
    assign err            = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

endmodule
